// File: rtl/start_done_pkg.sv
// rtl/start_done_pkg.sv - shared types and limits for the start/done burst responder
package start_done_pkg;

    localparam int CNT_W   = 4;
    localparam int MAX_LEN = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/start_done_responder_if.sv
// rtl/start_done_responder_if.sv - start/done burst handshake signal bundle
// master: drives start/sel, observes burst lines and status
// slave:  the responder; receives start/sel, drives a/b/done/busy/overrun
interface start_done_responder_if;
    logic start;
    logic sel;
    logic a;
    logic b;
    logic done;
    logic busy;
    logic overrun;

    modport master (
        output start, sel,
        input  a, b, done, busy, overrun
    );

    modport slave (
        input  start, sel,
        output a, b, done, busy, overrun
    );
endinterface

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered rising-edge detector with selectable reset value
// clk, rst_n : clock and synchronous active-low reset
// rst_val    : value loaded into the history flop during reset
// d          : level input
// rise       : d high now and low at the previous edge
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic rise
);
    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= rst_val;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/start_done_responder.sv
// rtl/start_done_responder.sv - drives a BURST_LEN burst on a or b per start rise, then a done pulse
// clk, rst_n : clock and synchronous active-low reset
// bus        : slave side of the handshake (start, sel in; a, b, done, busy, overrun out)
module start_done_responder
    import start_done_pkg::*;
#(
    parameter int BURST_LEN = 2,
    parameter int GAP_LEN   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    start_done_responder_if.slave   bus
);

    if (BURST_LEN < 1 || BURST_LEN > MAX_LEN) begin : g_bad_burst_len
        $error("start_done_responder: BURST_LEN outside 1..15");
    end
    if (GAP_LEN < 0 || GAP_LEN > MAX_LEN) begin : g_bad_gap_len
        $error("start_done_responder: GAP_LEN outside 0..15");
    end

    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit               HAS_GAP    = (GAP_LEN > 0);

    logic rise;

    // History resets high so a start already asserted at reset release is not a request.
    edge_det u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (1'b1),
        .d       (bus.start),
        .rise    (rise)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    sel_d   = bus.sel;
                    cnt_d   = BURST_LOAD;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear the cycle after the edge
        // that enters the state, keeping every output a plain flop.
        a_d       = (state_d == BURST) & ~sel_d;
        b_d       = (state_d == BURST) &  sel_d;
        done_d    = (state_d == DONE);
        busy_d    = (state_d != IDLE);
        overrun_d = rise & (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            a_q       <= a_d;
            b_q       <= b_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_start_done_responder.sv
// tb/tb_start_done_responder.sv - self-checking bench for start_done_responder over three parameter sets
module tb_start_done_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic start_v;
    logic sel_v;

    always #5 clk = ~clk;

    start_done_responder_if bus0 ();
    start_done_responder_if bus1 ();
    start_done_responder_if bus2 ();

    assign bus0.start = start_v;
    assign bus0.sel   = sel_v;
    assign bus1.start = start_v;
    assign bus1.sel   = sel_v;
    assign bus2.start = start_v;
    assign bus2.sel   = sel_v;

    start_done_responder #(.BURST_LEN(2), .GAP_LEN(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    start_done_responder #(.BURST_LEN(3), .GAP_LEN(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    start_done_responder #(.BURST_LEN(1), .GAP_LEN(15)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // {a, b, done, busy, overrun}
    logic [4:0] obs [3];
    assign obs[0] = {bus0.a, bus0.b, bus0.done, bus0.busy, bus0.overrun};
    assign obs[1] = {bus1.a, bus1.b, bus1.done, bus1.busy, bus1.overrun};
    assign obs[2] = {bus2.a, bus2.b, bus2.done, bus2.busy, bus2.overrun};

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a request occupies the responder for bl+gp+1 cycles after
    // the accepting edge; elapsed counts edges since acceptance.
    int  bl [3] = '{2, 3, 1};
    int  gp [3] = '{0, 2, 15};
    bit  act [3];
    int  elapsed [3];
    bit  sel_m [3];
    bit  prev_start;
    logic [4:0] expv [3];

    string names [5] = '{"a", "b", "done", "busy", "overrun"};

    task automatic step(input bit s, input bit sl, input bit r);
        bit rise;
        bit ov;
        start_v = s;
        sel_v   = sl;
        rst_n   = r;
        @(posedge clk);
        rise = s & ~prev_start;
        for (int c = 0; c < 3; c++) begin
            if (!r) begin
                act[c]  = 1'b0;
                sel_m[c] = 1'b0;
                expv[c] = 5'b0;
            end else begin
                ov = rise & act[c];
                if (act[c]) begin
                    elapsed[c]++;
                    if (elapsed[c] > bl[c] + gp[c]) act[c] = 1'b0;
                end else if (rise) begin
                    act[c]     = 1'b1;
                    elapsed[c] = 0;
                    sel_m[c]   = sl;
                end
                expv[c][4] = act[c] && (elapsed[c] < bl[c]) && !sel_m[c];
                expv[c][3] = act[c] && (elapsed[c] < bl[c]) &&  sel_m[c];
                expv[c][2] = act[c] && (elapsed[c] == bl[c] + gp[c]);
                expv[c][1] = act[c];
                expv[c][0] = ov;
            end
        end
        prev_start = r ? s : 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                assert (obs[c][4-k] === expv[c][4-k]) else begin
                    miscompares++;
                    $error("FAIL %s cfg%0d t=%0t observed=%b expected=%b",
                           names[k], c, $time, obs[c][4-k], expv[c][4-k]);
                end
            end
            vectors++;
            assert (!(obs[c][4] === 1'b1 && obs[c][3] === 1'b1)) else begin
                miscompares++;
                $error("FAIL a_b_exclusive cfg%0d t=%0t observed=%b expected=0", c, $time, 1'b1);
            end
        end
    endtask

    task automatic idle(input int n, input bit sl);
        for (int i = 0; i < n; i++) step(1'b0, sl, 1'b1);
    endtask

    initial begin
        prev_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            act[c] = 1'b0; elapsed[c] = 0; sel_m[c] = 1'b0; expv[c] = 5'b0;
        end
        start_v = 1'b0;
        sel_v   = 1'b0;
        rst_n   = 1'b0;

        // Reset for two edges, then basic A burst
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(20, 1'b0);

        // B burst (gap visible on the 3/2 and 1/15 instances)
        step(1'b1, 1'b1, 1'b1);
        idle(20, 1'b1);

        // Dropped rise two edges after acceptance
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(20, 1'b0);

        // Rise at the done edge of the 2/0 instance, then a later accepted rise
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        idle(20, 1'b0);

        // Rise one edge after the done edge is accepted immediately
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        idle(20, 1'b0);

        // Reset mid-burst with start held high across release
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        idle(4, 1'b0);

        // sel toggled every cycle after acceptance
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, i[0] == 1'b0, 1'b1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
